// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//   Streams one polynomial (BN*MA coefficients, natural order) into a banked
//   coefficient memory. It applies one conditional subtraction of the modulus
//   to each coefficient, then launches the NTT core and waits for it to finish.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   modulus       : NTT modulus, held stable for the whole load
//   load_req      : one-cycle pulse that starts a load (honoured only in IDLE)
//   in_valid/in_ready/in_data/in_last : coefficient input handshake
//   wr_en/wr_bank/wr_addr/wr_data     : registered memory write port
//   ntt_start     : one-cycle launch pulse, issued the cycle after the last write
//   ntt_done      : completion from the NTT core (honoured only in WAIT)
//   busy          : high whenever the loader is not IDLE
//   load_err      : sticky framing error (in_last on the wrong coefficient)
//   done          : one-cycle pulse after the NTT core reports completion
// -----------------------------------------------------------------------------
module mem_loader #(
   parameter  int D_width = 32,
   parameter  int BN      = 16,
   parameter  int MA      = 256,
   localparam int AW      = $clog2(MA),
   localparam int BW      = $clog2(BN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_width-1:0] modulus,
   input  logic               load_req,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [D_width-1:0] in_data,
   input  logic               in_last,
   output logic               wr_en,
   output logic [BW-1:0]      wr_bank,
   output logic [AW-1:0]      wr_addr,
   output logic [D_width-1:0] wr_data,
   output logic               ntt_start,
   input  logic               ntt_done,
   output logic               busy,
   output logic               load_err,
   output logic               done
);

   localparam int              CW       = AW + BW;
   localparam logic [CW-1:0]   LAST_IDX = CW'(BN * MA - 1);
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               load_err_q, load_err_d;
   logic               wr_en_q, wr_en_d;
   logic [BW-1:0]      wr_bank_q, wr_bank_d;
   logic [AW-1:0]      wr_addr_q, wr_addr_d;
   logic [D_width-1:0] wr_data_q, wr_data_d;
   logic               ntt_start_q, ntt_start_d;
   logic               done_q, done_d;
   logic               last_idx_s;

   // Inputs are below 2*modulus, so one conditional subtraction is a full reduction.
   function automatic logic [D_width-1:0] reduce_mod(input logic [D_width-1:0] x,
                                                      input logic [D_width-1:0] m);
      logic [D_width-1:0] r;
      if (x >= m) begin
         r = x - m;
      end else begin
         r = x;
      end
      return r;
   endfunction

   assign last_idx_s = (cnt_q == LAST_IDX);

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_err_d  = load_err_q;
      wr_en_d     = 1'b0;
      wr_bank_d   = wr_bank_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      ntt_start_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_req) begin
               state_d    = S_LOAD;
               cnt_d      = '0;
               load_err_d = 1'b0;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               wr_en_d   = 1'b1;
               // Low counter bits select the bank, high bits the address.
               wr_bank_d = cnt_q[BW-1:0];
               wr_addr_d = cnt_q[CW-1:BW];
               wr_data_d = reduce_mod(in_data, modulus);
               cnt_d     = cnt_q + CNT_ONE;
               // Framing error when in_last disagrees with the final index.
               if (in_last != last_idx_s) begin
                  load_err_d = 1'b1;
               end else begin
                  load_err_d = load_err_q;
               end
               if (last_idx_s) begin
                  state_d = S_START;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_START: begin
            // START coincides with the final write; the registered launch
            // pulse therefore lands one cycle after it.
            ntt_start_d = 1'b1;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            if (ntt_done) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         load_err_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_bank_q   <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ntt_start_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_err_q  <= load_err_d;
         wr_en_q     <= wr_en_d;
         wr_bank_q   <= wr_bank_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         ntt_start_q <= ntt_start_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q != S_IDLE);
   assign wr_en     = wr_en_q;
   assign wr_bank   = wr_bank_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign ntt_start = ntt_start_q;
   assign load_err  = load_err_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
//   Randomised self-checking bench for mem_loader. A behavioural model tracks
//   the loader's phases and predicts the outputs of every cycle. It is checked
//   against the DUT on each falling edge. A few literal expectations pin the
//   model: reduction boundaries, the coefficient 17 mapping, write counts, and
//   the ntt_start and done timing.
// -----------------------------------------------------------------------------
module tb_mem_loader;

   localparam int          DW   = 32;
   localparam int          BN   = 16;
   localparam int          MA   = 256;
   localparam int          AW   = 8;
   localparam int          BW   = 4;
   localparam int          DEG  = BN * MA;
   localparam logic [31:0] MOD  = 32'd167772161;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] modulus = MOD;
   logic          load_req = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          wr_en;
   logic [BW-1:0] wr_bank;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          ntt_start;
   logic          ntt_done = 1'b0;
   logic          busy;
   logic          load_err;
   logic          done;

   mem_loader #(.D_width(DW), .BN(BN), .MA(MA)) dut (
      .clk(clk), .rst(rst), .modulus(modulus), .load_req(load_req),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .ntt_start(ntt_start), .ntt_done(ntt_done), .busy(busy),
      .load_err(load_err), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic longint ref_reduce(input longint x, input longint m);
      return (x >= m) ? x - m : x;
   endfunction

   // ---------------- behavioural model (updated at each rising edge) --------
   bit     m_loading = 0, m_waiting = 0, m_err = 0;
   int     m_start_cd = 0;
   int     m_n = 0;
   bit     e_wr_en = 0, e_start = 0, e_done = 0;
   int     e_bank = 0, e_addr = 0;
   longint e_data = 0;

   initial forever begin
      bit was_idle;
      @(posedge clk);
      if (rst) begin
         m_loading = 0; m_waiting = 0; m_err = 0; m_start_cd = 0; m_n = 0;
         e_wr_en = 0; e_start = 0; e_done = 0;
      end else begin
         was_idle = !m_loading && (m_start_cd == 0) && !m_waiting;
         e_wr_en = 0; e_start = 0; e_done = 0;
         if (m_waiting && ntt_done) begin
            e_done = 1; m_waiting = 0;
         end
         if (m_start_cd == 1) begin
            e_start = 1; m_start_cd = 0; m_waiting = 1;
         end
         if (m_loading && in_valid) begin
            e_wr_en = 1;
            e_bank  = m_n % BN;
            e_addr  = m_n / BN;
            e_data  = ref_reduce(longint'(in_data), longint'(modulus));
            if (in_last != (m_n == DEG - 1)) m_err = 1;
            if (m_n == DEG - 1) begin
               m_loading = 0; m_start_cd = 1;
            end else begin
               m_n++;
            end
         end
         if (was_idle && load_req) begin
            m_loading = 1; m_n = 0; m_err = 0;
         end
      end
   end

   // ---------------- compare process + write capture (falling edge) ---------
   int cyc = 0;
   int last_wr_cyc = 0;
   int start_cyc = 0;
   int start_cnt = 0;
   int cap_bank[$];
   int cap_addr[$];
   longint cap_data[$];

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         cyc++;
         chk("wr_en", wr_en, e_wr_en);
         chk("in_ready", in_ready, m_loading);
         chk("busy", busy, m_loading || (m_start_cd != 0) || m_waiting);
         chk("load_err", load_err, m_err);
         chk("ntt_start", ntt_start, e_start);
         chk("done", done, e_done);
         if (e_wr_en) begin
            chk("wr_bank", wr_bank, e_bank);
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
         end
         if (wr_en) begin
            cap_bank.push_back(int'(wr_bank));
            cap_addr.push_back(int'(wr_addr));
            cap_data.push_back(longint'(wr_data));
            last_wr_cyc = cyc;
         end
         if (ntt_start) begin
            start_cnt++;
            start_cyc = cyc;
         end
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   function automatic logic [DW-1:0] pattern_data(input int idx);
      case (idx)
         10:      return 32'd167772161;
         11:      return 32'd167772160;
         12:      return 32'd335544321;
         default: return DW'(idx);
      endcase
   endfunction

   // Drive one load: stop_at < DEG halts after that many transfers (no tail).
   task automatic do_load(input int valid_pct, input int last_at, input int stop_at,
                          input bit use_pattern, input int ign_at, output int sent);
      int  idx = 0;
      int  guard = 0;
      bit  vld;
      @(posedge clk); #1; load_req = 1'b1;
      @(posedge clk); #1; load_req = 1'b0;
      chk("load_err_cleared", load_err, 0);
      while (idx < stop_at && guard < 40000) begin
         in_valid = ($urandom_range(0, 99) < valid_pct);
         if (use_pattern) in_data = pattern_data(idx);
         else if ($urandom_range(0, 7) == 0) in_data = MOD - 32'd1 + DW'($urandom_range(0, 2));
         else in_data = DW'($urandom_range(0, 335544321));
         in_last  = (idx == last_at);
         ntt_done = (idx == ign_at);
         load_req = (idx == ign_at + 1);
         vld = in_valid && in_ready;
         @(posedge clk); #1;
         if (vld) idx++;
         guard++;
      end
      ntt_done = 1'b0; load_req = 1'b0; in_last = 1'b0;
      sent = idx;
      chk("load_transfers", idx, stop_at);
   endtask

   // After the final transfer: wait for ntt_start, poke WAIT, then finish it.
   task automatic finish_ntt(input int starts_before);
      int g = 0;
      in_valid = 1'b0;
      while (!ntt_start && g < 20) begin
         @(posedge clk); #1; g++;
      end
      chk("ntt_start_seen", ntt_start, 1);
      @(posedge clk); #1;
      chk("ntt_start_count", start_cnt, starts_before + 1);
      chk("start_after_last_wr", start_cyc - last_wr_cyc, 1);
      chk("ntt_start_one_cycle", ntt_start, 0);
      load_req = 1'b1;                    // must be ignored in WAIT
      @(posedge clk); #1; load_req = 1'b0;
      chk("busy_in_wait", busy, 1);
      ntt_done = 1'b1;
      @(posedge clk); #1; ntt_done = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_after_done", busy, 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", in_ready, 0);
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      int base;
      int sent;
      int seq_bad;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_bank", wr_bank, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_ntt_start", ntt_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      // ntt_done while IDLE is ignored
      @(posedge clk); #1; ntt_done = 1'b1;
      @(posedge clk); #1; ntt_done = 1'b0;
      chk("idle_ntt_done_ignored", done, 0);

      // Load 1: continuous, natural data with reduction boundary values.
      base = cap_data.size();
      do_load(100, DEG - 1, DEG, 1'b1, 50, sent);
      finish_ntt(0);
      chk("load1_writes", cap_data.size() - base, 4096);
      chk("n17_bank", cap_bank[base + 17], 1);
      chk("n17_addr", cap_addr[base + 17], 1);
      chk("n17_data", cap_data[base + 17], 17);
      chk("red_eq_mod", cap_data[base + 10], 0);
      chk("red_mod_m1", cap_data[base + 11], 167772160);
      chk("red_2mod_m1", cap_data[base + 12], 167772160);
      chk("last_bank", cap_bank[base + 4095], 15);
      chk("last_addr", cap_addr[base + 4095], 255);
      chk("load1_no_err", load_err, 0);

      // Load 2: 50% valid, random data; address sequence must stay in order.
      base = cap_data.size();
      do_load(50, DEG - 1, DEG, 1'b0, -10, sent);
      finish_ntt(1);
      chk("load2_writes", cap_data.size() - base, 4096);
      seq_bad = 0;
      for (int i = 0; i < DEG; i++)
         if (cap_bank[base + i] != i % BN || cap_addr[base + i] != i / BN) seq_bad++;
      chk("load2_addr_seq_errors", seq_bad, 0);

      // Load 3: in_last early at n=100 -> sticky error, load still completes.
      base = cap_data.size();
      do_load(80, 100, DEG, 1'b0, -10, sent);
      chk("early_last_err", load_err, 1);
      finish_ntt(2);
      chk("load3_writes", cap_data.size() - base, 4096);
      chk("err_sticky_after_done", load_err, 1);

      // Load 4: reset after 2000 transfers, with a transfer offered at the reset edge.
      base = cap_data.size();
      do_load(60, DEG - 1, 2000, 1'b0, -10, sent);
      in_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("rst_mid_wr_en", wr_en, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (8) @(posedge clk);
      #1; in_valid = 1'b0;
      chk("rst_mid_writes", cap_data.size() - base, 2000);
      chk("rst_mid_no_start", start_cnt, 3);
      chk("rst_mid_idle", in_ready, 0);

      // Load 5: fresh load after the reset starts at bank 0 addr 0.
      base = cap_data.size();
      do_load(100, DEG - 1, DEG, 1'b1, -10, sent);
      finish_ntt(3);
      chk("reload_first_bank", cap_bank[base], 0);
      chk("reload_first_addr", cap_addr[base], 0);
      chk("reload_writes", cap_data.size() - base, 4096);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
